// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: March C- style BIST controller for a single-port synchronous SRAM.
// Sequence: W0_UP (write P), R0W1_UP (read P, write ~P), R1W0_DN (read ~P, write P),
// R0_DN (read P), then one FLUSH cycle so the last read is compared.
// Optional build macro BIST_FAIL_LOG_EN: when defined, the first mismatching address and
// read data are captured in fail_addr/fail_data; when undefined, both are tied to zero.
module sram_bist_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int WMASK_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic [DATA_W-1:0]  pattern,
    output logic               csb0,
    output logic               web0,
    output logic [WMASK_W-1:0] wmask0,
    output logic [ADDR_W-1:0]  addr0,
    output logic [DATA_W-1:0]  din0,
    input  logic [DATA_W-1:0]  dout0,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [ADDR_W-1:0]  fail_addr,
    output logic [DATA_W-1:0]  fail_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W0_UP   = 3'd1,
        R0W1_UP = 3'd2,
        R1W0_DN = 3'd3,
        R0_DN   = 3'd4,
        FLUSH   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t              state, state_nxt;
    logic                phase, phase_nxt;      // 0: read slot, 1: write slot of a two-cycle element
    logic [ADDR_W-1:0]   last_q, last_nxt;
    logic [DATA_W-1:0]   pat_q, pat_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   din_nxt;
    logic [WMASK_W-1:0]  wmask_nxt;
    logic                csb_nxt, web_nxt;
    logic                busy_nxt, done_nxt;
    logic                start_acc;
    logic                vld_nxt, vld_p0, vld_p1;
    logic [DATA_W-1:0]   exp_nxt, exp_p0, exp_p1;
    logic                mismatch;

    // Background selection: the true pattern or its complement.
    function automatic logic [DATA_W-1:0] bg(input logic [DATA_W-1:0] p, input logic inv);
        return inv ? ~p : p;
    endfunction

    // Next-state, address sequencing and registered-output decode.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        addr_nxt  = addr0;
        last_nxt  = last_q;
        pat_nxt   = pat_q;
        start_acc = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    start_acc = 1'b1;
                    last_nxt  = last_addr;
                    pat_nxt   = pattern;
                    state_nxt = W0_UP;
                    addr_nxt  = '0;
                    phase_nxt = 1'b0;
                end
            end
            W0_UP: begin
                if (addr0 == last_q) begin
                    state_nxt = R0W1_UP;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr0 + ONE;
                end
            end
            R0W1_UP: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (addr0 == last_q) begin
                        state_nxt = R1W0_DN;
                        addr_nxt  = last_q;
                    end else begin
                        addr_nxt = addr0 + ONE;
                    end
                end
            end
            R1W0_DN: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (addr0 == '0) begin
                        state_nxt = R0_DN;
                        addr_nxt  = last_q;
                    end else begin
                        addr_nxt = addr0 - ONE;
                    end
                end
            end
            R0_DN: begin
                if (addr0 == '0) begin
                    state_nxt = FLUSH;
                end else begin
                    addr_nxt = addr0 - ONE;
                end
            end
            FLUSH:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        // abort wins over start and over any sequencing step
        if (abort) begin
            state_nxt = IDLE;
            phase_nxt = 1'b0;
        end

        csb_nxt   = 1'b1;
        web_nxt   = 1'b1;
        wmask_nxt = '0;
        din_nxt   = din0;
        vld_nxt   = 1'b0;
        exp_nxt   = bg(pat_nxt, 1'b0);
        case (state_nxt)
            W0_UP: begin
                csb_nxt   = 1'b0;
                web_nxt   = 1'b0;
                wmask_nxt = '1;
                din_nxt   = bg(pat_nxt, 1'b0);
            end
            R0W1_UP: begin
                csb_nxt = 1'b0;
                if (!phase_nxt) begin
                    vld_nxt = 1'b1;
                    exp_nxt = bg(pat_nxt, 1'b0);
                end else begin
                    web_nxt   = 1'b0;
                    wmask_nxt = '1;
                    din_nxt   = bg(pat_nxt, 1'b1);
                end
            end
            R1W0_DN: begin
                csb_nxt = 1'b0;
                if (!phase_nxt) begin
                    vld_nxt = 1'b1;
                    exp_nxt = bg(pat_nxt, 1'b1);
                end else begin
                    web_nxt   = 1'b0;
                    wmask_nxt = '1;
                    din_nxt   = bg(pat_nxt, 1'b0);
                end
            end
            R0_DN: begin
                csb_nxt = 1'b0;
                vld_nxt = 1'b1;
                exp_nxt = bg(pat_nxt, 1'b0);
            end
            default: ;
        endcase

        busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
        done_nxt = (state_nxt == DONE);
    end

    // Stage p0: state, latched configuration and registered SRAM controls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            phase  <= 1'b0;
            last_q <= '0;
            pat_q  <= '0;
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            last_q <= last_nxt;
            pat_q  <= pat_nxt;
            csb0   <= csb_nxt;
            web0   <= web_nxt;
            wmask0 <= wmask_nxt;
            addr0  <= addr_nxt;
            din0   <= din_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            vld_p0 <= vld_nxt;
            vld_p1 <= vld_p0 & ~abort;
        end
    end

    // Stage p1: expected-data pipeline aligned with dout0 (data only, no reset needed).
    always_ff @(posedge clk) begin
        exp_p0 <= exp_nxt;
        exp_p1 <= exp_p0;
    end

    assign mismatch = vld_p1 && (dout0 != exp_p1);

    // Sticky fail flag, cleared only when a new test is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fail <= 1'b0;
        end else if (start_acc) begin
            fail <= 1'b0;
        end else if (mismatch) begin
            fail <= 1'b1;
        end
    end

`ifdef BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] raddr_p0, raddr_p1;

    // Read address pipeline, aligned with exp_p1 for first-failure logging.
    always_ff @(posedge clk) begin
        raddr_p0 <= addr_nxt;
        raddr_p1 <= raddr_p0;
    end

    // Capture address and data of the first mismatch of the current test.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (start_acc) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch && !fail) begin
            fail_addr <= raddr_p1;
            fail_data <= dout0;
        end
    end
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl with a behavioural synchronous SRAM and
// a selectable stuck-at-0 fault on bit 0 of one address.
module tb_sram_bist_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [9:0]  last_addr;
    logic [31:0] pattern;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [9:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        busy, done, fail;
    logic [9:0]  fail_addr;
    logic [31:0] fail_data;

    logic        fault_en;
    logic [9:0]  fault_addr;
    logic [31:0] mem [0:1023];

    int          n_checks = 0;
    int          n_errors = 0;
    int          acc_n;
    int          max_addr;
    logic [46:0] acc_log [64];

    sram_bist_ctrl #(.ADDR_W(10), .DATA_W(32), .WMASK_W(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .last_addr (last_addr),
        .pattern   (pattern),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears in the cycle after the read.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= mem[addr0] & ((fault_en && addr0 == fault_addr) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            end
        end
    end

    // Access recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (!csb0) begin
            if (acc_n < 64)
                acc_log[acc_n] = {!web0, (!web0 ? wmask0 : 4'h0), addr0, (!web0 ? din0 : 32'h0)};
            acc_n = acc_n + 1;
            if (int'(addr0) > max_addr) max_addr = int'(addr0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_test(input logic [9:0] la, input logic [31:0] pat);
        @(negedge clk);
        acc_n     = 0;
        max_addr  = 0;
        last_addr = la;
        pattern   = pat;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
    endtask

    int          cyc;
    int          ea [24] = '{0,1,2,3, 0,0,1,1,2,2,3,3, 3,3,2,2,1,1,0,0, 3,2,1,0};
    int          ek [24] = '{1,1,1,1, 0,2,0,2,0,2,0,2, 0,1,0,1,0,1,0,1, 0,0,0,0};
    logic [31:0] p;
    logic [46:0] e;

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        last_addr  = '0;
        pattern    = '0;
        fault_en   = 1'b0;
        fault_addr = '0;
        acc_n      = 0;
        max_addr   = 0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_csb0", 64'(csb0), 64'd1);
        check("rst_web0", 64'(web0), 64'd1);
        check("rst_wmask0", 64'(wmask0), 64'd0);
        check("rst_addr0", 64'(addr0), 64'd0);
        check("rst_din0", 64'(din0), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);
        check("rst_fail_addr", 64'(fail_addr), 64'd0);
        check("rst_fail_data", 64'(fail_data), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // good memory, last_addr=3, full access sequence
        p = 32'hA5A5_A5A5;
        start_test(10'd3, p);
        check("good_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("good_cycles", 64'(cyc), 64'd25);
        check("good_fail", 64'(fail), 64'd0);
        check("good_busy_end", 64'(busy), 64'd0);
        check("good_csb_done", 64'(csb0), 64'd1);
        check("good_acc_n", 64'(acc_n), 64'd24);
        for (int i = 0; i < 24; i++) begin
            e = {ek[i] != 0, (ek[i] != 0) ? 4'hF : 4'h0, 10'(ea[i]),
                 (ek[i] == 1) ? p : ((ek[i] == 2) ? ~p : 32'h0)};
            check($sformatf("good_acc%0d", i), 64'(acc_log[i]), 64'(e));
        end

        // stuck-at-0 bit 0 at address 2, pattern 0
        fault_en   = 1'b1;
        fault_addr = 10'd2;
        start_test(10'd3, 32'h0);
        wait_done(cyc);
        check("sa0_cycles", 64'(cyc), 64'd25);
        check("sa0_fail", 64'(fail), 64'd1);
`ifdef BIST_FAIL_LOG_EN
        check("sa0_fail_addr", 64'(fail_addr), 64'd2);
        check("sa0_fail_data", 64'(fail_data), 64'hFFFF_FFFE);
`else
        check("sa0_fail_addr", 64'(fail_addr), 64'd0);
        check("sa0_fail_data", 64'(fail_data), 64'd0);
`endif

        // new start clears fail
        fault_en = 1'b0;
        start_test(10'd3, 32'h1234_5678);
        check("restart_fail_clr", 64'(fail), 64'd0);
        wait_done(cyc);
        check("restart_cycles", 64'(cyc), 64'd25);
        check("restart_fail", 64'(fail), 64'd0);

        // last_addr=0, plus a start while busy that must be ignored
        start_test(10'd0, 32'hFFFF_0000);
        @(negedge clk);
        last_addr = 10'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        check("one_word_cycles", 64'(cyc + 1), 64'd7);
        check("one_word_max_addr", 64'(max_addr), 64'd0);
        check("one_word_acc_n", 64'(acc_n), 64'd6);
        check("one_word_fail", 64'(fail), 64'd0);

        // abort and start together in DONE: abort wins
        @(negedge clk);
        acc_n = 0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_pri_done", 64'(done), 64'd0);
        check("abort_pri_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_pri_acc", 64'(acc_n), 64'd0);

        // abort during R1W0_DN
        start_test(10'd3, 32'h0F0F_0F0F);
        repeat (14) @(posedge clk);
        #1;
        check("r1w0_rd_csb", 64'({csb0, web0}), 64'b01);
        check("r1w0_rd_addr", 64'(addr0), 64'd2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_csb0", 64'(csb0), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_fail", 64'(fail), 64'd0);
        acc_n = 0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_acc", 64'(acc_n), 64'd0);
        check("abort_done_late", 64'(done), 64'd0);

        // asynchronous reset mid-W0_UP
        start_test(10'd3, 32'hA5A5_A5A5);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_csb0", 64'(csb0), 64'd1);
        check("arst_web0", 64'(web0), 64'd1);
        check("arst_addr0", 64'(addr0), 64'd0);
        check("arst_din0", 64'(din0), 64'd0);
        check("arst_wmask0", 64'(wmask0), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        acc_n  = 0;
        repeat (5) @(posedge clk);
        #1;
        check("arst_no_acc", 64'(acc_n), 64'd0);
        start_test(10'd3, 32'hA5A5_A5A5);
        wait_done(cyc);
        check("arst_rerun_cycles", 64'(cyc), 64'd25);
        check("arst_rerun_fail", 64'(fail), 64'd0);
        check("arst_rerun_acc", 64'(acc_n), 64'd24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_bist_ctrl.md
SRAM_BIST_CTRL -- requirements
Module: sram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 32: SRAM data width.
REQ-003 SHALL have parameter WMASK_W, default 4: SRAM write-mask width.
REQ-004 SHALL have port clk  input  1: single clock for all logic; it is the same clock that drives the SRAM under test.
REQ-005 SHALL have port resetn  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: one-cycle request that begins a test; sampled only in IDLE or DONE.
REQ-007 SHALL have port abort  input  1: ends a running test immediately and returns to IDLE.
REQ-008 SHALL have port last_addr  input  ADDR_W: highest address to test, sampled at start.
REQ-009 SHALL have port pattern  input  DATA_W: background data P, sampled at start; the complement ~P is the second background.
REQ-010 SHALL have port csb0  output  1: active-low SRAM chip select.
REQ-011 SHALL have port web0  output  1: active-low SRAM write enable.
REQ-012 SHALL have port wmask0  output  WMASK_W: write mask.
REQ-013 SHALL have port addr0  output  ADDR_W: SRAM address.
REQ-014 SHALL have port din0  output  DATA_W: SRAM write data.
REQ-015 SHALL have port dout0  input  DATA_W: SRAM read data, valid in the cycle after the read is issued.
REQ-016 SHALL have port busy  output  1: high while a test runs.
REQ-017 SHALL have port done  output  1: high in DONE until the next start, abort or reset.
REQ-018 SHALL have port fail  output  1: sticky mismatch flag for the current test.
REQ-019 SHALL have port fail_addr  output  ADDR_W: address of the first mismatch.
REQ-020 SHALL have port fail_data  output  DATA_W: dout0 value at the first mismatch.

Function
REQ-021 SHALL implement states IDLE, W0_UP, R0W1_UP, R1W0_DN, R0_DN, FLUSH, DONE.
REQ-022 start in IDLE or DONE SHALL:
- latch last_addr and pattern;
- clear fail, fail_addr and fail_data;
- enter W0_UP with address 0.
REQ-023 W0_UP SHALL write P at one address per cycle, ascending 0..last_addr, then enter R0W1_UP at address 0.
REQ-024 R0W1_UP SHALL use two cycles per address, ascending: a read expecting P, then a write of ~P; after last_addr it enters R1W0_DN at last_addr.
REQ-025 R1W0_DN SHALL use two cycles per address, descending: a read expecting ~P, then a write of P; after address 0 it enters R0_DN at last_addr.
REQ-026 R0_DN SHALL read one address per cycle, descending, expecting P; after address 0 it enters FLUSH.
REQ-027 FLUSH SHALL last one cycle so the final read is compared, then enter DONE.
REQ-028 Read cycle: csb0=0, web0=1. Write cycle: csb0=0, web0=0, wmask0 all ones. All other cycles: csb0=1, web0=1.
REQ-029 Each read SHALL be compared in the next cycle by registering the expected value and a compare-valid bit.
- On mismatch, fail SHALL be set.
- Only the first mismatch SHALL be recorded in fail_addr/fail_data.
REQ-030 Address counting SHALL stop exactly at the bound and never wrap; last_addr=0 tests one word.
REQ-031 Total test length SHALL be 6*(last_addr+1)+1 cycles from the cycle after start to entry into DONE.
REQ-032 start while busy SHALL be ignored.
REQ-033 abort SHALL take priority over start and over state advance; it forces IDLE with csb0=1 on the next edge, and fail is held.
REQ-034 Outputs addr0, din0 and csb0/web0 SHALL be registered; compare logic SHALL be a single pipeline stage.

Reset
REQ-035 resetn low SHALL asynchronously force:
- state IDLE;
- csb0=1, web0=1, wmask0=0, addr0=0, din0=0;
- busy=0, done=0, fail=0, fail_addr=0, fail_data=0;
- latched config = 0.
REQ-036 Reset mid-test SHALL abandon the test with no further SRAM access until a new start.

Configuration
REQ-037 Macro BIST_FAIL_LOG_EN defined: fail_addr and fail_data capture the first mismatch as above.
REQ-038 BIST_FAIL_LOG_EN undefined: fail_addr and fail_data SHALL be constant 0 with no capture registers; fail is unaffected.

Verification
REQ-039 Good SRAM model, last_addr=3, pattern=32'hA5A5_A5A5, start -> DONE after 25 cycles, fail=0, the access sequence matches REQ-023..026.
REQ-040 Stuck-at-0 on bit 0 at address 2, pattern=0 -> fail=1, fail_addr=2, fail_data=32'hFFFF_FFFE (first fault detected in R1W0_DN).
REQ-041 abort asserted in R1W0_DN -> IDLE next cycle, csb0=1, busy=0, done=0, no further accesses.
REQ-042 resetn dropped mid-W0_UP, asynchronous to clk -> outputs reach reset values immediately; a following start runs the full test.
REQ-043 last_addr=0 -> 7 cycles to DONE, no address exceeds 0; start while busy -> ignored, with last_addr unchanged.
REQ-044 BIST_FAIL_LOG_EN undefined with a faulty model -> fail=1, fail_addr=0, fail_data=0.
